// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the two-port memory read arbiter.
// Holds the FSM state encoding, port indices and the round-robin pick.
package mem_read_arbiter_pkg;

    localparam int unsigned CNT_W = 3;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DLOAD  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    // On a tie the port that did not win last time gets the grant.
    function automatic logic arb_pick(input logic req0, input logic req1, input logic last_grant);
        logic pick;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else if (req1) begin
            pick = PORT_DLOAD;
        end else begin
            pick = PORT_IFETCH;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_req_slot.sv
// One requester slot: pending flag, latched address, read-data register and
// the one-cycle valid pulse returned to the requester.
module mem_req_slot #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              strb,
    input  logic [ADDR_W-1:0] addr,
    input  logic              complete,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              req_c,
    output logic [ADDR_W-1:0] req_addr_c,
    output logic              pending,
    output logic [ADDR_W-1:0] pend_addr,
    output logic              rbusy,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              accept_c;

    // A strobe while the slot is occupied is a protocol violation and is dropped.
    assign accept_c = strb & ~pending_q;

    always_comb begin
        pending_d = pending_q;
        addr_d    = addr_q;
        rvalid_d  = complete;
        rdata_d   = rdata_q;
        if (accept_c) begin
            pending_d = 1'b1;
            addr_d    = addr;
        end
        if (complete) begin
            pending_d = 1'b0;
            rdata_d   = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            addr_q    <= addr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // An idle arbiter may grant a fresh strobe directly, so expose it alongside the slot.
    assign req_c      = pending_q | strb;
    assign req_addr_c = pending_q ? addr_q : addr;

    assign pending    = pending_q;
    assign pend_addr  = addr_q;
    assign rbusy      = pending_q;
    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin read arbiter sharing one registered-read memory between the
// instruction-fetch port (0) and the data-load port (1).
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_rstrb,
    output logic              m0_rbusy,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_rstrb,
    output logic              m1_rbusy,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rstrb,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rstrb_q, mem_rstrb_d;
    logic              complete_c;

    logic              req0_c, req1_c;
    logic [ADDR_W-1:0] req_addr0_c, req_addr1_c;
    logic              pend0, pend1;
    logic [ADDR_W-1:0] pend_addr0, pend_addr1;
    logic              pick_c;
    logic              other_c;
    logic              other_pend_c;

    mem_req_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot_ifetch (
        .clk        (clk),
        .resetn     (resetn),
        .strb       (m0_rstrb),
        .addr       (m0_addr),
        .complete   (complete_c && (gnt_q == PORT_IFETCH)),
        .mem_rdata  (mem_rdata),
        .req_c      (req0_c),
        .req_addr_c (req_addr0_c),
        .pending    (pend0),
        .pend_addr  (pend_addr0),
        .rbusy      (m0_rbusy),
        .rvalid     (m0_rvalid),
        .rdata      (m0_rdata)
    );

    mem_req_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot_dload (
        .clk        (clk),
        .resetn     (resetn),
        .strb       (m1_rstrb),
        .addr       (m1_addr),
        .complete   (complete_c && (gnt_q == PORT_DLOAD)),
        .mem_rdata  (mem_rdata),
        .req_c      (req1_c),
        .req_addr_c (req_addr1_c),
        .pending    (pend1),
        .pend_addr  (pend_addr1),
        .rbusy      (m1_rbusy),
        .rvalid     (m1_rvalid),
        .rdata      (m1_rdata)
    );

    assign pick_c       = arb_pick(req0_c, req1_c, last_grant_q);
    assign other_c      = ~gnt_q;
    assign other_pend_c = (other_c == PORT_DLOAD) ? pend1 : pend0;

    // Next-state, grant and memory-side strobe/address.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_rstrb_d  = 1'b0;
        complete_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req0_c || req1_c) begin
                    state_d      = ST_ISSUE;
                    gnt_d        = pick_c;
                    last_grant_d = pick_c;
                    mem_addr_d   = (pick_c == PORT_DLOAD) ? req_addr1_c : req_addr0_c;
                    mem_rstrb_d  = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(LATENCY - 1);
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    complete_c = 1'b1;
                    // The completing port's own strobes were dropped while busy, so only the other can be waiting.
                    if (other_pend_c) begin
                        state_d      = ST_ISSUE;
                        gnt_d        = other_c;
                        last_grant_d = other_c;
                        mem_addr_d   = (other_c == PORT_DLOAD) ? pend_addr1 : pend_addr0;
                        mem_rstrb_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            gnt_q        <= PORT_IFETCH;
            last_grant_q <= PORT_DLOAD;
            mem_addr_q   <= '0;
            mem_rstrb_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_rstrb_q  <= mem_rstrb_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rstrb = mem_rstrb_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: scoreboarded LATENCY=1 instance
// plus a LATENCY=3 instance checked for cycle timing.
module tb_mem_read_arbiter;

    logic        clk = 1'b0;
    logic        resetn;

    logic [31:0] m0_addr, m1_addr, mem_addr, mem_rdata, m0_rdata, m1_rdata;
    logic        m0_rstrb, m1_rstrb, m0_rbusy, m1_rbusy, m0_rvalid, m1_rvalid, mem_rstrb;

    logic [31:0] b_m0_addr, b_m1_addr, b_mem_addr, b_mem_rdata, b_m0_rdata, b_m1_rdata;
    logic        b_m0_rstrb, b_m1_rstrb, b_m0_rbusy, b_m1_rbusy, b_m0_rvalid, b_m1_rvalid, b_mem_rstrb;
    logic [31:0] b_p1, b_p2;

    logic [31:0] mem [0:63];
    logic [31:0] iss_q[$];
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int r0, r1;

    always #5 clk = ~clk;

    mem_read_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_dut (
        .clk(clk), .resetn(resetn),
        .m0_addr(m0_addr), .m0_rstrb(m0_rstrb), .m0_rbusy(m0_rbusy), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_addr(m1_addr), .m1_rstrb(m1_rstrb), .m1_rbusy(m1_rbusy), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata)
    );

    mem_read_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3)) u_dut_lat3 (
        .clk(clk), .resetn(resetn),
        .m0_addr(b_m0_addr), .m0_rstrb(b_m0_rstrb), .m0_rbusy(b_m0_rbusy), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_addr(b_m1_addr), .m1_rstrb(b_m1_rstrb), .m1_rbusy(b_m1_rbusy), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .mem_addr(b_mem_addr), .mem_rstrb(b_mem_rstrb), .mem_rdata(b_mem_rdata)
    );

    // Memory models: data is valid LATENCY cycles after the strobe, junk otherwise.
    always_ff @(posedge clk) begin
        mem_rdata <= mem_rstrb ? mem[mem_addr[7:2]] : 32'hDEAD_BEEF;
        b_p1      <= b_mem_rstrb ? mem[b_mem_addr[7:2]] : 32'hDEAD_BEEF;
        b_p2      <= b_p1;
        b_mem_rdata <= b_p2;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        m0_rstrb = 1'b0; m1_rstrb = 1'b0; b_m0_rstrb = 1'b0; b_m1_rstrb = 1'b0;
    endtask

    task automatic strobe(input int port, input logic [31:0] addr, input bit accept);
        if (port == 0) begin
            m0_rstrb = 1'b1; m0_addr = addr;
            if (accept) exp0_q.push_back(mem[addr[7:2]]);
        end else begin
            m1_rstrb = 1'b1; m1_addr = addr;
            if (accept) exp1_q.push_back(mem[addr[7:2]]);
        end
        if (accept) iss_q.push_back(addr);
    endtask

    // Scoreboard: issue order/address and returned data per port.
    always @(negedge clk) begin
        if (resetn) begin
            if (mem_rstrb) begin
                if (iss_q.size() == 0) check_eq("issue_unexpected", {31'd0, mem_rstrb}, 32'd0);
                else check_eq("issue_addr", mem_addr, iss_q.pop_front());
            end
            if (m0_rvalid) begin
                if (exp0_q.size() == 0) check_eq("m0_rvalid_unexpected", {31'd0, m0_rvalid}, 32'd0);
                else check_eq("m0_rdata", m0_rdata, exp0_q.pop_front());
            end
            if (m1_rvalid) begin
                if (exp1_q.size() == 0) check_eq("m1_rvalid_unexpected", {31'd0, m1_rvalid}, 32'd0);
                else check_eq("m1_rdata", m1_rdata, exp1_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i * 7 + 1);
        mem[9] = 32'h0010_0093;
        resetn = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_rstrb = 1'b0; m1_rstrb = 1'b0;
        b_m0_addr = '0; b_m1_addr = '0; b_m0_rstrb = 1'b0; b_m1_rstrb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_m0_rbusy", {31'd0, m0_rbusy}, 32'd0);
        check_eq("rst_m1_rbusy", {31'd0, m1_rbusy}, 32'd0);
        check_eq("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        check_eq("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        check_eq("rst_m0_rdata", m0_rdata, 32'd0);
        check_eq("rst_m1_rdata", m1_rdata, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_rstrb", {31'd0, mem_rstrb}, 32'd0);
        check_eq("rst_b_mem_rstrb", {31'd0, b_mem_rstrb}, 32'd0);
        resetn = 1'b1;
        step();

        // Simultaneous strobes: port 0 wins the first tie.
        strobe(0, 32'h00, 1'b1); strobe(1, 32'h40, 1'b1);
        step();
        check_eq("sim_c1_rstrb", {31'd0, mem_rstrb}, 32'd1);
        check_eq("sim_c1_addr", mem_addr, 32'h00);
        check_eq("sim_c1_m1_rbusy", {31'd0, m1_rbusy}, 32'd1);
        step(); step();
        check_eq("sim_c3_rstrb", {31'd0, mem_rstrb}, 32'd1);
        check_eq("sim_c3_addr", mem_addr, 32'h40);
        check_eq("sim_c3_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
        check_eq("sim_c3_m0_rbusy", {31'd0, m0_rbusy}, 32'd0);
        step(); step();
        check_eq("sim_c5_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
        check_eq("sim_c5_m1_rbusy", {31'd0, m1_rbusy}, 32'd0);
        repeat (3) step();

        // Single uncontended read.
        strobe(0, 32'h24, 1'b1);
        step();
        check_eq("one_c1_rstrb", {31'd0, mem_rstrb}, 32'd1);
        check_eq("one_c1_addr", mem_addr, 32'h24);
        check_eq("one_c1_rbusy", {31'd0, m0_rbusy}, 32'd1);
        step();
        check_eq("one_c2_rbusy", {31'd0, m0_rbusy}, 32'd1);
        check_eq("one_c2_rvalid", {31'd0, m0_rvalid}, 32'd0);
        check_eq("one_c2_rstrb", {31'd0, mem_rstrb}, 32'd0);
        step();
        check_eq("one_c3_rvalid", {31'd0, m0_rvalid}, 32'd1);
        check_eq("one_c3_rdata", m0_rdata, 32'h0010_0093);
        check_eq("one_c3_rbusy", {31'd0, m0_rbusy}, 32'd0);
        repeat (3) step();

        // Strobe while busy is dropped.
        strobe(1, 32'h10, 1'b1);
        step();
        strobe(1, 32'h20, 1'b0);
        repeat (6) step();
        check_eq("busy_m1_rdata", m1_rdata, mem[4]);
        check_eq("busy_mem_addr", mem_addr, 32'h10);

        // Fairness: each port re-strobes in its rvalid cycle.
        r0 = 1; r1 = 1;
        strobe(0, 32'h80, 1'b1); strobe(1, 32'hC0, 1'b1);
        for (int c = 0; c < 14; c++) begin
            step();
            if (m0_rvalid && r0 < 3) begin strobe(0, 32'h80 + 32'(4 * r0), 1'b1); r0++; end
            if (m1_rvalid && r1 < 3) begin strobe(1, 32'hC0 + 32'(4 * r1), 1'b1); r1++; end
        end
        check_eq("fair_m0_rounds", 32'(r0), 32'd3);
        check_eq("fair_m1_rounds", 32'(r1), 32'd3);
        repeat (4) step();

        // Reset during WAIT discards the in-flight read.
        strobe(0, 32'h08, 1'b1);
        step(); step();
        resetn = 1'b0;
        #1;
        exp0_q.delete();
        check_eq("rstw_mem_rstrb", {31'd0, mem_rstrb}, 32'd0);
        check_eq("rstw_mem_addr", mem_addr, 32'd0);
        check_eq("rstw_m0_rbusy", {31'd0, m0_rbusy}, 32'd0);
        check_eq("rstw_m0_rdata", m0_rdata, 32'd0);
        step();
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("rstw_no_rvalid", {31'd0, m0_rvalid}, 32'd0);
        end
        strobe(0, 32'h24, 1'b1);
        step();
        check_eq("post_c1_rstrb", {31'd0, mem_rstrb}, 32'd1);
        step(); step();
        check_eq("post_c3_rvalid", {31'd0, m0_rvalid}, 32'd1);
        check_eq("post_c3_rdata", m0_rdata, 32'h0010_0093);
        repeat (2) step();

        // LATENCY=3 instance: timing and back-to-back grant.
        b_m0_rstrb = 1'b1; b_m0_addr = 32'h24;
        step();
        check_eq("l3_c1_rstrb", {31'd0, b_mem_rstrb}, 32'd1);
        check_eq("l3_c1_addr", b_mem_addr, 32'h24);
        b_m1_rstrb = 1'b1; b_m1_addr = 32'h30;
        step();
        check_eq("l3_c2_rbusy", {31'd0, b_m0_rbusy}, 32'd1);
        step(); step();
        check_eq("l3_c4_rvalid", {31'd0, b_m0_rvalid}, 32'd0);
        step();
        check_eq("l3_c5_rvalid", {31'd0, b_m0_rvalid}, 32'd1);
        check_eq("l3_c5_rdata", b_m0_rdata, 32'h0010_0093);
        check_eq("l3_c5_rstrb", {31'd0, b_mem_rstrb}, 32'd1);
        check_eq("l3_c5_addr", b_mem_addr, 32'h30);
        step(); step(); step();
        check_eq("l3_c8_m1_rvalid", {31'd0, b_m1_rvalid}, 32'd0);
        step();
        check_eq("l3_c9_m1_rvalid", {31'd0, b_m1_rvalid}, 32'd1);
        check_eq("l3_c9_m1_rdata", b_m1_rdata, mem[12]);
        repeat (2) step();

        check_eq("sb_issue_drained", 32'(iss_q.size()), 32'd0);
        check_eq("sb_m0_drained", 32'(exp0_q.size()), 32'd0);
        check_eq("sb_m1_drained", 32'(exp1_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
